program_loader: RTL and testbench

Byte-stream writer that fills the instruction memory the CPU fetch path reads from. It receives a framed program image one byte at a time and assembles each group of four bytes into a 28-bit instruction word. Each word goes out as a single-cycle write into the instruction RAM at consecutive addresses. The CPU is held in reset until a frame completes with a valid checksum.

---
 rtl/program_loader.sv | 150 +++++++++++++++
 tb/tb_program_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Framed byte-stream loader for the instruction RAM: sync, 16-bit word count, 4-byte words,
// payload checksum. The CPU is held in reset until a frame completes with a good checksum.
module program_loader #(
  parameter logic [15:0] BASE_ADDR = 16'd0,
  parameter logic [15:0] MAX_WORDS = 16'd256
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [7:0]  iData,
  input  logic        iValid,
  output logic        oReady,
  input  logic        iAck,
  output logic        oWriteEnable,
  output logic [15:0] oWriteAddress,
  output logic [27:0] oWriteData,
  output logic        oCpuHold,
  output logic        oDone,
  output logic        oError
);

  typedef enum logic [2:0] {
    StIdle,
    StCntHi,
    StCntLo,
    StData,
    StCheck,
    StDone,
    StError
  } state_e;

  state_e      state_q;
  logic [15:0] count_q;
  logic [15:0] word_cnt_q;
  logic [1:0]  idx_q;
  logic [7:0]  csum_q;
  logic [23:0] asm_q;

  logic        accept;
  logic [15:0] count_full;
  logic [15:0] word_cnt_inc;

  assign accept       = iValid && oReady;
  assign count_full   = {count_q[15:8], iData};
  assign word_cnt_inc = word_cnt_q + 16'd1;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q       <= StIdle;
      count_q       <= '0;
      word_cnt_q    <= '0;
      idx_q         <= '0;
      csum_q        <= '0;
      asm_q         <= '0;
      oReady        <= 1'b0;
      oWriteEnable  <= 1'b0;
      oWriteAddress <= BASE_ADDR;
      oWriteData    <= '0;
      oCpuHold      <= 1'b1;
      oDone         <= 1'b0;
      oError        <= 1'b0;
    end else begin
      oWriteEnable <= 1'b0;
      // Ready everywhere except ERROR; the branches entering ERROR override this.
      oReady       <= 1'b1;
      case (state_q)
        StIdle: begin
          if (accept && iData == 8'hA5) begin
            state_q    <= StCntHi;
            csum_q     <= '0;
            word_cnt_q <= '0;
            idx_q      <= '0;
          end
        end
        StCntHi: begin
          if (accept) begin
            count_q[15:8] <= iData;
            state_q       <= StCntLo;
          end
        end
        StCntLo: begin
          if (accept) begin
            count_q[7:0] <= iData;
            word_cnt_q   <= '0;
            idx_q        <= '0;
            if (count_full > MAX_WORDS) begin
              state_q <= StError;
              oError  <= 1'b1;
              oReady  <= 1'b0;
            end else if (count_full == 16'd0) begin
              state_q <= StCheck;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (accept) begin
            csum_q <= csum_q + iData;
            asm_q  <= {asm_q[15:0], iData};
            idx_q  <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              // asm_q holds B0..B2; only the low nibble of B0 reaches the word.
              oWriteEnable  <= 1'b1;
              oWriteAddress <= BASE_ADDR + word_cnt_q;
              oWriteData    <= {asm_q[19:0], iData};
              word_cnt_q    <= word_cnt_inc;
              if (word_cnt_inc == count_q) begin
                state_q <= StCheck;
              end
            end
          end
        end
        StCheck: begin
          if (accept) begin
            if (iData == csum_q) begin
              state_q  <= StDone;
              oDone    <= 1'b1;
              oCpuHold <= 1'b0;
            end else begin
              state_q <= StError;
              oError  <= 1'b1;
              oReady  <= 1'b0;
            end
          end
        end
        StDone: begin
          if (accept && iData == 8'hA5) begin
            state_q    <= StCntHi;
            oCpuHold   <= 1'b1;
            oDone      <= 1'b0;
            csum_q     <= '0;
            word_cnt_q <= '0;
            idx_q      <= '0;
          end
        end
        StError: begin
          oReady <= iAck;
          if (iAck) begin
            state_q <= StIdle;
            oError  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good/bad frames, count limit, gaps, reload, reset abort.
module tb_program_loader;

  logic        Clock;
  logic        Reset;
  logic [7:0]  iData;
  logic        iValid;
  logic        oReady;
  logic        iAck;
  logic        oWriteEnable;
  logic [15:0] oWriteAddress;
  logic [27:0] oWriteData;
  logic        oCpuHold;
  logic        oDone;
  logic        oError;

  int tests_run;
  int tests_failed;

  // Write log captured mid-cycle, away from the active edge.
  int          wr_cnt;
  logic [15:0] wr_addr [16];
  logic [27:0] wr_data [16];

  program_loader #(
    .BASE_ADDR(16'hFFFF),
    .MAX_WORDS(16'd4)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iData        (iData),
    .iValid       (iValid),
    .oReady       (oReady),
    .iAck         (iAck),
    .oWriteEnable (oWriteEnable),
    .oWriteAddress(oWriteAddress),
    .oWriteData   (oWriteData),
    .oCpuHold     (oCpuHold),
    .oDone        (oDone),
    .oError       (oError)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (oWriteEnable) begin
      if (wr_cnt < 16) begin
        wr_addr[wr_cnt] = oWriteAddress;
        wr_data[wr_cnt] = oWriteData;
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the byte is offered across the next posedge, returns at the next negedge.
  task automatic send_byte(input logic [7:0] b);
    iData  = b;
    iValid = 1'b1;
    @(negedge Clock);
    iValid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] bytes [$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic check_log(input string tag, input int idx, input logic [15:0] a,
                           input logic [27:0] d);
    if (idx < wr_cnt && idx < 16) begin
      check_eq({tag, "_addr"}, {16'h0, wr_addr[idx]}, {16'h0, a});
      check_eq({tag, "_data"}, {4'h0, wr_data[idx]}, {4'h0, d});
    end else begin
      check_eq({tag, "_missing"}, wr_cnt, idx + 1);
    end
  endtask

  task automatic check_status(input string tag, input logic rdy, input logic hold,
                              input logic done, input logic err);
    check_eq({tag, "_ready"}, {31'h0, oReady}, {31'h0, rdy});
    check_eq({tag, "_hold"}, {31'h0, oCpuHold}, {31'h0, hold});
    check_eq({tag, "_done"}, {31'h0, oDone}, {31'h0, done});
    check_eq({tag, "_error"}, {31'h0, oError}, {31'h0, err});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    wr_cnt       = 0;
    Reset        = 1'b0;
    iData        = 8'h00;
    iValid       = 1'b0;
    iAck         = 1'b0;

    // Reset values
    idle(2);
    check_status("rst", 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("rst_we", {31'h0, oWriteEnable}, 32'h0);
    check_eq("rst_addr", {16'h0, oWriteAddress}, 32'h0000_FFFF);
    check_eq("rst_data", {4'h0, oWriteData}, 32'h0);
    Reset = 1'b1;
    idle(1);
    check_eq("rst_ready_after", {31'h0, oReady}, 32'h1);

    // Two-word load; payload sum 01+AA+BB+CC+0E+11+22+33 = 2A6 -> A6
    send_bytes('{8'hA5, 8'h00, 8'h02, 8'h01, 8'hAA, 8'hBB, 8'hCC});
    check_eq("w0_we", {31'h0, oWriteEnable}, 32'h1);
    check_eq("w0_addr_live", {16'h0, oWriteAddress}, 32'h0000_FFFF);
    check_eq("w0_data_live", {4'h0, oWriteData}, 32'h01AA_BBCC);
    send_byte(8'h0E);
    check_eq("w0_we_single", {31'h0, oWriteEnable}, 32'h0);
    send_bytes('{8'h11, 8'h22, 8'h33});
    check_status("load_before_ck", 1'b1, 1'b1, 1'b0, 1'b0);
    send_byte(8'hA6);
    check_status("load_done", 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("load_wr_cnt", wr_cnt, 2);
    check_log("load_w0", 0, 16'hFFFF, 28'h1AABBCC);
    check_log("load_w1", 1, 16'h0000, 28'hE112233);

    // Non-sync byte in DONE is discarded; A5 starts a reload; zero count reaches DONE
    send_byte(8'h00);
    check_status("done_junk", 1'b1, 1'b0, 1'b1, 1'b0);
    send_byte(8'hA5);
    check_status("reload", 1'b1, 1'b1, 1'b0, 1'b0);
    send_bytes('{8'h00, 8'h00, 8'h00});
    check_status("zero_done", 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("zero_wr_cnt", wr_cnt, 2);

    // Bad checksum: writes still happen, then ERROR
    send_bytes('{8'hA5, 8'h00, 8'h02, 8'h01, 8'hAA, 8'hBB, 8'hCC,
                 8'h0E, 8'h11, 8'h22, 8'h33, 8'hE4});
    check_status("badck", 1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("badck_wr_cnt", wr_cnt, 4);
    check_log("badck_w0", 2, 16'hFFFF, 28'h1AABBCC);
    check_log("badck_w1", 3, 16'h0000, 28'hE112233);
    idle(2);
    check_status("err_hold", 1'b0, 1'b1, 1'b0, 1'b1);

    // iAck alongside a valid byte: byte ignored, back to IDLE
    iAck = 1'b1;
    send_byte(8'hA5);
    iAck = 1'b0;
    check_status("ack", 1'b1, 1'b1, 1'b0, 1'b0);

    // Count over limit (MAX_WORDS = 4)
    send_bytes('{8'hA5, 8'h00, 8'h05});
    check_status("over", 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1);
    iAck = 1'b1;
    idle(1);
    iAck = 1'b0;
    check_status("over_ack", 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("over_wr_cnt", wr_cnt, 4);

    // Count equal to the limit is accepted; then reset after two payload bytes
    send_bytes('{8'hA5, 8'h00, 8'h04});
    check_status("limit_ok", 1'b1, 1'b1, 1'b0, 1'b0);
    send_bytes('{8'h12, 8'h34});
    #1 Reset = 1'b0;
    #1;
    check_status("midrst", 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("midrst_addr", {16'h0, oWriteAddress}, 32'h0000_FFFF);
    check_eq("midrst_data", {4'h0, oWriteData}, 32'h0);
    check_eq("midrst_we", {31'h0, oWriteEnable}, 32'h0);
    @(negedge Clock);
    Reset = 1'b1;
    idle(1);
    check_eq("midrst_ready", {31'h0, oReady}, 32'h1);

    // Garbage before sync and 3-cycle gaps; loads from BASE_ADDR again
    send_bytes('{8'h00, 8'hFF});
    begin
      logic [7:0] frame [$];
      frame = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h07, 8'h07};
      foreach (frame[i]) begin
        send_byte(frame[i]);
        idle(3);
      end
    end
    check_status("gap_done", 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("gap_wr_cnt", wr_cnt, 5);
    check_log("gap_w0", 4, 16'hFFFF, 28'h0000007);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
